// File: rtl/pattern_ser_pkg.sv
// Shared types and sizing helpers for the pattern bit serializer.
// SER_PARITY_EN appends one even-parity bit to every frame.
package pattern_ser_pkg;

  typedef enum logic {StIdle, StShift} ser_state_e;

`ifdef SER_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic int unsigned frame_len(input int unsigned w);
    return w + ParityBits;
  endfunction

endpackage

// File: rtl/pattern_ser_hold.sv
// One-entry holding buffer; accepts a word when empty, releases it on rd_i.
module pattern_ser_hold #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_i,
  input  logic [W-1:0] data_i,
  input  logic         rd_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output logic         ready_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (rd_i) vld_d = 1'b0;
    if (wr_i) begin
      vld_d  = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o   = vld_q;
  assign data_o  = data_q;
  assign ready_o = !vld_q && !rst_i;

endmodule

// File: rtl/pattern_bit_serializer.sv
// Parallel-to-serial feeder for the pattern detector with a one-word skid buffer.
// Define SER_PARITY_EN to append an even-parity bit to each frame.
module pattern_bit_serializer
  import pattern_ser_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter bit          LSB_FIRST = 1'b0,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         x,
  output logic         x_valid,
  output logic         busy
);

  localparam int unsigned CntW = cnt_width(W);
  localparam int unsigned Frame = frame_len(W);
  localparam logic [CntW-1:0] LastCnt = CntW'(Frame - 1);
`ifdef SER_PARITY_EN
  localparam logic [CntW-1:0] LastDataCnt = CntW'(W - 1);
`endif

  ser_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic            x_q, x_d;
  logic            x_valid_q, x_valid_d;
`ifdef SER_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic         hold_vld, hold_ready, hold_wr, hold_rd;
  logic [W-1:0] hold_data;
  logic         accept, frame_end, load;
  logic [W-1:0] load_word;

  function automatic logic first_bit(input logic [W-1:0] w);
    return LSB_FIRST ? w[0] : w[W-1];
  endfunction

  // shreg holds the not-yet-emitted bits, next one always at the output end
  function automatic logic [W-1:0] drop_bit(input logic [W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  pattern_ser_hold #(
    .W(W)
  ) u_hold (
    .clk_i  (clk),
    .rst_i  (rst),
    .wr_i   (hold_wr),
    .data_i (din),
    .rd_i   (hold_rd),
    .vld_o  (hold_vld),
    .data_o (hold_data),
    .ready_o(hold_ready)
  );

  assign din_ready = hold_ready;
  assign accept    = din_valid && din_ready;
  assign frame_end = (state_q == StShift) && (cnt_q == LastCnt);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
`ifdef SER_PARITY_EN
    parity_d  = parity_q;
`endif
    hold_wr   = 1'b0;
    hold_rd   = 1'b0;
    load      = 1'b0;
    load_word = din;

    unique case (state_q)
      StIdle: begin
        if (accept) load = 1'b1;
      end
      StShift: begin
        if (frame_end) begin
          if (hold_vld) begin
            load      = 1'b1;
            load_word = hold_data;
            hold_rd   = 1'b1;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d   = StIdle;
            cnt_d     = '0;
            x_d       = IDLE_BIT;
            x_valid_d = 1'b0;
          end
        end else begin
          hold_wr = accept;
          cnt_d   = cnt_q + 1'b1;
          shreg_d = drop_bit(shreg_q);
`ifdef SER_PARITY_EN
          x_d     = (cnt_q == LastDataCnt) ? parity_q
                                           : (LSB_FIRST ? shreg_q[0] : shreg_q[W-1]);
`else
          x_d     = LSB_FIRST ? shreg_q[0] : shreg_q[W-1];
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d   = StShift;
      cnt_d     = '0;
      x_d       = first_bit(load_word);
      x_valid_d = 1'b1;
      shreg_d   = drop_bit(load_word);
`ifdef SER_PARITY_EN
      parity_d  = ^load_word;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      x_q       <= IDLE_BIT;
      x_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
`ifdef SER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = (state_q == StShift) || hold_vld;

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream.
// Honours SER_PARITY_EN the same way as the design.
module tb_pattern_bit_serializer;

  localparam int unsigned W = 8;
  localparam bit IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy0, x0, xv0, busy0;
  logic         rdy1, x1, xv1, busy1;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  bit qm[$];
  bit ql[$];

  pattern_bit_serializer #(
    .W(W), .LSB_FIRST(1'b0), .IDLE_BIT(IDLE_BIT)
  ) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .x(x0), .x_valid(xv0), .busy(busy0)
  );

  pattern_bit_serializer #(
    .W(W), .LSB_FIRST(1'b1), .IDLE_BIT(IDLE_BIT)
  ) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .x(x1), .x_valid(xv1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word is taken whenever fewer than one full frame is pending.
  always @(posedge clk) begin
    if (rst) begin
      qm.delete();
      ql.delete();
    end else if (din_valid && qm.size() < FRAME) begin
      for (int i = W - 1; i >= 0; i--) qm.push_back(din[i]);
      for (int i = 0; i < W; i++) ql.push_back(din[i]);
`ifdef SER_PARITY_EN
      qm.push_back(^din);
      ql.push_back(^din);
`endif
    end
  end

  task automatic check_port(input string nm, input logic xv, input logic xb, input logic bsy,
                            input logic rdy, input int qsize, input logic expbit);
    cmp({nm, " x_valid"}, xv, qsize != 0);
    cmp({nm, " busy"}, bsy, qsize != 0);
    cmp({nm, " din_ready"}, rdy, !rst && (qsize <= FRAME));
    if (xv && qsize != 0) cmp({nm, " x"}, xb, expbit);
    else if (!xv) cmp({nm, " idle x"}, xb, IDLE_BIT);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_port("msb", xv0, x0, busy0, rdy0, qm.size(), (qm.size() != 0) ? qm[0] : IDLE_BIT);
      check_port("lsb", xv1, x1, busy1, rdy1, ql.size(), (ql.size() != 0) ? ql[0] : IDLE_BIT);
      if (xv0 && qm.size() != 0) void'(qm.pop_front());
      if (xv1 && ql.size() != 0) void'(ql.pop_front());
    end
  end

  task automatic send(input logic [W-1:0] w);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    din       = w;
    din_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept timeout: got no din_ready expected accept of %h", w);
    end
    #1;
    din_valid = 1'b0;
    din       = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (qm.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (qm.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain timeout: got %0d bits pending expected 0", qm.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    din       = 8'hA5;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(8'hA5);
    wait_idle();

    send(8'hA5);
    send(8'h3C);
    wait_idle();

    send(8'hA5);
    send(8'h3C);
    send(8'h07);
    wait_idle();

    send(8'h01);
    wait_idle();

    send(8'h07);
    wait_idle();

    // reset mid-frame with a word parked in the holding buffer
    send(8'hA5);
    send(8'h3C);
    @(posedge clk);
    #1;
    pulse_reset();
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 19) == 0) pulse_reset();
      send(W'($urandom));
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_bit_serializer.md
Name: pattern_bit_serializer

Overview:
- Upstream feeder for the serial pattern-detector stage. Converts parallel words from a valid/ready source into a registered one-bit-per-clock stream on x, with a qualifying x_valid.
- A one-entry holding buffer absorbs the next word while the current one shifts out, so back-to-back words stream with no bubble cycles.
- Idle cycles drive a fixed fill bit so the downstream detector sees a defined level.

Parameters:
- W, 8, data word width in bits (W >= 2)
- LSB_FIRST, 0, 0 = shift MSB first; 1 = shift LSB first
- IDLE_BIT, 1'b0, value driven on x when no word is shifting

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- din  input  W  parallel word
- din_valid  input  1  din is valid
- din_ready  output  1  block can accept din this cycle
- x  output  1  registered serial bit to the detector
- x_valid  output  1  x carries a data (or parity) bit
- busy  output  1  a frame is shifting or the holding buffer is occupied

Behaviour:
- Reset (rst=1 at a clk edge): x=IDLE_BIT, x_valid=0, busy=0, holding buffer empty, state IDLE, bit counter 0. din_ready=0 while rst is high. Reset mid-frame discards the shifting word and the buffered word, with no partial output.
- Accept: a word transfers on a clk edge where din_valid && din_ready. din_ready = !hold_vld && !rst. A valid word may not change until it transfers.
- States:
  - IDLE: x=IDLE_BIT, x_valid=0. On accept, load the shift register, go to SHIFT, and register x <= first bit at that same edge. Latency: accept at edge k, first bit visible after edge k.
  - SHIFT: one bit per clock, x_valid=1. The bit counter counts 0..FRAME-1, where FRAME=W (W+1 with parity). After edge k+FRAME-1 the last bit is on x.
- Frame end, at the edge that would emit bit FRAME, in priority order:
  - Holding buffer valid: load it, emit its first bit, clear hold_vld, stay in SHIFT.
  - Otherwise din_valid && din_ready: bypass-load din directly, stay in SHIFT.
  - Otherwise: go to IDLE, x <= IDLE_BIT, x_valid <= 0.
- While in SHIFT and not at frame end: an accept writes the holding buffer, setting hold_vld and dropping din_ready the next cycle.
- Simultaneous frame end, buffer emptying and a new din_valid: the buffer is consumed, din_ready rises the next cycle, and din waits.
- Bit order: MSB first (din[W-1]..din[0]) when LSB_FIRST=0; din[0]..din[W-1] otherwise.
- busy = (state==SHIFT) || hold_vld. Registered outputs are x and x_valid. din_ready and busy are decoded from registers only, with no din-to-output combinational path.
- Counter width is $clog2(W+1). No wrap beyond FRAME-1.

Optional Feature:
- Macro SER_PARITY_EN.
- When defined: each frame appends one even-parity bit (XOR of the W data bits) after the last data bit, with x_valid=1. FRAME=W+1, and the holding/bypass handoff occurs after the parity bit.
- When undefined: FRAME=W, no parity bit, and no parity logic is instantiated.

Decomposition:
- Package pattern_ser_pkg holds:
  - the state enum (IDLE, SHIFT)
  - a function returning the counter width for W
  - the FRAME length constant derived from the macro
- Natural sub-module: pattern_ser_hold, the one-entry holding buffer with valid/ready. The shift FSM stays in the top.

Test Plan:
- Reset: rst=1 for 3 clocks with din_valid=1 -> x=IDLE_BIT, x_valid=0, din_ready=0, busy=0. No word accepted.
- Single word W=8, din=8'hA5, MSB first -> x sequence 1,0,1,0,0,1,0,1 on 8 consecutive x_valid cycles, starting the cycle after accept. Then x_valid=0 and x=IDLE_BIT.
- Back-to-back 8'hA5 then 8'h3C held valid -> 16 contiguous x_valid cycles carrying 10100101 00111100. din_ready low while the buffer is full. No bubble.
- LSB_FIRST=1, din=8'h01 -> x = 1,0,0,0,0,0,0,0.
- SER_PARITY_EN defined: 8'hA5 -> 9 bits, last bit 0. 8'h07 -> last bit 1. The next buffered word starts immediately after the parity bit.
- Reset asserted at the 4th bit with a word buffered -> the next cycle shows x_valid=0, busy=0, x=IDLE_BIT. The buffered word is never emitted after reset deasserts.
